// File: rtl/div_pkg.sv
// Shared constants and state type for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Counter width for an arbitrary operand width (holds WIDTH down to 0).
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   prem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH:0]   prem_next,
    output logic             qbit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted   = {prem, bit_in};
        diff      = shifted - {2'b00, dvs_mag};
        qbit      = ~diff[WIDTH+1];
        prem_next = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2*WIDTH / WIDTH restoring division, one quotient bit per clock.
// Optional simulation checker enabled with `define DIV_SELFCHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring iteration per cycle, WIDTH cycles
// FIX   | apply signs, late overflow check, register results
// DONE  | one-cycle done pulse; a start here is accepted
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = div_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] Q_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state, state_nx;

    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     pr;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   dvd_lo;
    logic               sign_q;
    logic               sign_r;

    logic [2*WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0]   dvs_mag_in;
    logic               dvs_zero;
    logic               early_ovf;
    logic               late_ovf;
    logic               accept;
    logic [WIDTH:0]     pr_next;
    logic               qbit;

    always_comb begin
        dvd_mag_in = dividend[2*WIDTH-1] ? -dividend : dividend;
        dvs_mag_in = divisor[WIDTH-1] ? -divisor : divisor;
        dvs_zero   = (divisor == '0);
        early_ovf  = (dvd_mag_in[2*WIDTH-1:WIDTH] >= dvs_mag_in);
        late_ovf   = sign_q ? (lo > Q_MAX_NEG) : (lo > Q_MAX_POS);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (pr),
        .bit_in    (lo[WIDTH-1]),
        .dvs_mag   (dvs_mag),
        .prem_next (pr_next),
        .qbit      (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (dvs_zero || early_ovf) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (dvs_zero || early_ovf) ? S_FIX : S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            pr          <= '0;
            lo          <= '0;
            dvs_mag     <= '0;
            dvd_lo      <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            pr          <= {1'b0, dvd_mag_in[2*WIDTH-1:WIDTH]};
            lo          <= dvd_mag_in[WIDTH-1:0];
            dvs_mag     <= dvs_mag_in;
            dvd_lo      <= dividend[WIDTH-1:0];
            sign_q      <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            sign_r      <= dividend[2*WIDTH-1];
            cnt         <= CW'(WIDTH);
            div_by_zero <= dvs_zero;
            overflow    <= !dvs_zero && early_ovf;
        end else if (state == S_RUN) begin
            pr  <= pr_next;
            lo  <= {lo[WIDTH-2:0], qbit};
            cnt <= cnt - CW'(1);
        end else if (state == S_FIX) begin
            if (div_by_zero) begin
                quotient  <= '0;
                remainder <= dvd_lo;
            end else if (overflow || late_ovf) begin
                quotient  <= '0;
                remainder <= '0;
                overflow  <= 1'b1;
            end else begin
                // Remainder magnitude is below |divisor| <= 2^(WIDTH-1), so it fits WIDTH bits.
                quotient  <= sign_q ? -lo : lo;
                remainder <= sign_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
            end
        end
    end

`ifdef DIV_SELFCHECK_EN
    logic [2*WIDTH-1:0] chk_dvd;
    logic [WIDTH-1:0]   chk_dvs;
    longint             chk_q, chk_r, chk_d, chk_n;

    always_ff @(posedge clk) begin
        if (accept) begin
            chk_dvd <= dividend;
            chk_dvs <= divisor;
        end
    end

    always @(posedge clk) begin
        if (!rst && done) begin
            if (busy) $error("done and busy high together");
            if (!div_by_zero && !overflow) begin
                chk_q = longint'($signed(quotient));
                chk_r = longint'($signed(remainder));
                chk_d = longint'($signed(chk_dvs));
                chk_n = longint'($signed(chk_dvd));
                if ((chk_q * chk_d + chk_r != chk_n) ||
                    ((chk_r < 0 ? -chk_r : chk_r) >= (chk_d < 0 ? -chk_d : chk_d)))
                    $error("divider result inconsistent: %0d / %0d -> q=%0d r=%0d",
                           chk_n, chk_d, chk_q, chk_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomized and directed bench for seq_signed_divider against an integer-arithmetic model.
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy, done, div_by_zero, overflow;
    logic [7:0]  quotient, remainder;

    int total = 0;
    int bad   = 0;

    seq_signed_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Expected results straight from signed integer division (truncating toward zero).
    function automatic void model(input longint a, input longint b,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic edz, output logic eov, output int lat);
        longint ma, mb, q, r;
        edz = (b == 0); eov = 1'b0; q = 0; r = 0; lat = 10;
        if (edz) begin
            r = a; lat = 2;
        end else begin
            ma = (a < 0) ? -a : a;
            mb = (b < 0) ? -b : b;
            if ((ma / 256) >= mb) begin
                eov = 1'b1; lat = 2;
            end else begin
                q = a / b;
                r = a % b;
                if (q > 127 || q < -128) begin
                    eov = 1'b1; q = 0; r = 0;
                end
            end
        end
        eq = q[7:0];
        er = r[7:0];
    endfunction

    // Issues one start and waits (bounded) for done; returns edge count and busy samples.
    task automatic run_op(input longint a, input longint b, output int edges, output int busy_cnt);
        dividend = a[15:0];
        divisor  = b[7:0];
        start    = 1'b1;
        edges    = 0;
        busy_cnt = 0;
        @(posedge clk); edges = 1; #1;
        start = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); edges++; #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b ov=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, overflow, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        longint ta [9] = '{4900, -2765, 2765, 9, 1, 16384, 128, -128, -32768};
        longint tb [9] = '{-70, 40, -40, 0, 1, 1, 1, 1, -128};
        logic [7:0] eq, er;
        logic edz, eov;
        int lat, edges, bcnt;
        for (int i = 0; i < 9; i++) begin
            model(ta[i], tb[i], eq, er, edz, eov, lat);
            run_op(ta[i], tb[i], edges, bcnt);
            total++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
                bad++;
                $display("FAIL directed_%0d result: got q=%0d r=%0d dz=%b ov=%b, want q=%0d r=%0d dz=%b ov=%b",
                         i, $signed(quotient), $signed(remainder), div_by_zero, overflow,
                         $signed(eq), $signed(er), edz, eov);
            end
            total++;
            if (edges !== lat || bcnt !== lat - 1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL directed_%0d timing: got edges=%0d busy_cycles=%0d busy_at_done=%b, want %0d %0d 0",
                         i, edges, bcnt, busy, lat, lat - 1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_and_abort();
        int edges;
        logic seen_done;
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); edges = 1; #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); edges++; #1; end
        dividend = 16'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); edges++; #1;
        start = 1'b0;
        while (!done && edges < 40) begin @(posedge clk); edges++; #1; end
        total++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || edges !== 10) begin
            bad++;
            $display("FAIL ignored_start: got q=%0d r=%0d edges=%0d, want q=14 r=2 edges=10",
                     quotient, remainder, edges);
        end
        @(posedge clk); #1;
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 20'h0) begin
            bad++;
            $display("FAIL abort_reset: got busy=%b done=%b dz=%b ov=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, overflow, quotient, remainder);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got done pulse=%b, want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int edges, bcnt;
        run_op(1000, 9, edges, bcnt);
        total++;
        if (done !== 1'b1 || quotient !== 8'd111 || remainder !== 8'd1) begin
            bad++;
            $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want done=1 q=111 r=1",
                     done, quotient, remainder);
        end
        run_op(-1, 1, edges, bcnt);
        total++;
        if (edges !== 10 || quotient !== 8'hFF || remainder !== 8'h00 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got edges=%0d q=%h r=%h ov=%b, want edges=10 q=ff r=00 ov=0",
                     edges, quotient, remainder, overflow);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || quotient !== 8'hFF) begin
            bad++;
            $display("FAIL done_single_cycle: got done=%b q=%h, want done=0 q=ff", done, quotient);
        end
    endtask

    task automatic test_random();
        logic [15:0] raw;
        logic [7:0]  rb;
        longint a, b;
        logic [7:0] eq, er;
        logic edz, eov;
        int lat, edges, bcnt;
        for (int i = 0; i < 60; i++) begin
            raw = 16'($urandom);
            rb  = 8'($urandom);
            a = longint'($signed(raw));
            if (i % 3 == 1) a = a / 256;
            if (i % 10 == 0) rb = 8'h00;
            if (i % 10 == 5) rb = 8'h80;
            b = longint'($signed(rb));
            model(a, b, eq, er, edz, eov, lat);
            run_op(a, b, edges, bcnt);
            total++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov} || edges !== lat) begin
                bad++;
                $display("FAIL random_%0d %0d/%0d: got q=%0d r=%0d dz=%b ov=%b edges=%0d, want q=%0d r=%0d dz=%b ov=%b edges=%0d",
                         i, a, b, $signed(quotient), $signed(remainder), div_by_zero, overflow, edges,
                         $signed(eq), $signed(er), edz, eov, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed divider, the inverse of the team's signed Booth multiplier.
- Takes a 2*WIDTH-bit signed dividend (a product-width value) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder using restoring division on magnitudes, one quotient bit per clock.
- Sits beside booth_multiplier in the arithmetic datapath; uses a start/done handshake.

Parameters:
WIDTH, 8, operand width; dividend is 2*WIDTH bits, quotient and remainder are WIDTH bits.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
dividend  input  2*WIDTH  signed dividend; sampled with start
divisor  input  WIDTH  signed divisor; sampled with start
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign of dividend
div_by_zero  output  1  divisor was 0
overflow  output  1  quotient not representable in WIDTH signed bits

Behaviour:
- Reset (sync, active-high) forces state IDLE; busy, done, quotient, remainder, div_by_zero and overflow all go to 0. A mid-operation reset aborts with no done pulse.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch |dividend| (2*WIDTH bits), |divisor| (WIDTH bits), sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend); load counter=WIDTH; clear both error flags.
  - If divisor==0: set div_by_zero, go to FIX.
  - Else if upper WIDTH bits of |dividend| >= |divisor| (unsigned): set overflow (early), go to FIX.
  - Else go to RUN.
- RUN:
  - Each cycle, shift the partial-remainder:quotient register left 1 and trial-subtract |divisor| from the WIDTH+1-bit partial remainder.
  - If non-negative, keep the difference and shift in 1; otherwise restore and shift in 0.
  - Decrement counter; go to FIX when counter reaches 0 (exactly WIDTH cycles).
- FIX, with M = unsigned quotient magnitude:
  - Apply signs.
  - Late overflow if sign_q=0 and M > 2^(WIDTH-1)-1, or sign_q=1 and M > 2^(WIDTH-1).
  - Register outputs, go to DONE.
- Outputs by case:
  - Normal: quotient = signed result, remainder = signed result.
  - div_by_zero: quotient=0, remainder=dividend[WIDTH-1:0].
  - overflow: quotient=0, remainder=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE unless start is present; a start in DONE is accepted, giving back-to-back operation.
- Latency: done is high in the cycle after the WIDTH+2-th rising edge, counting the edge that samples start (10 for WIDTH=8). Error short-path: 2 edges.
- start is ignored while busy. Inputs need only be stable at the sampling edge.
- Results hold until the next accepted start or reset; flags clear on the next accepted start.
- Arithmetic: magnitudes are unsigned 2*WIDTH / WIDTH.
  - -2^(2*WIDTH-1) magnitude handled as unsigned 2^(2*WIDTH-1).
  - -2^(WIDTH-1) divisor magnitude is 2^(WIDTH-1).
- Invariant when no flag is set: quotient*divisor + remainder == dividend, and |remainder| < |divisor|.

Optional Feature:
- Macro DIV_SELFCHECK_EN.
- Defined: simulation-only checker. On each done with no flag set, compare quotient*divisor+remainder against the latched dividend and |remainder| < |divisor|; report $error with operands on mismatch. It also checks that done never coincides with busy.
- Undefined: no checker code; synthesized logic identical either way.

Decomposition:
- Package div_pkg holds:
  - the WIDTH default constant;
  - the state enum typedef (IDLE, RUN, FIX, DONE);
  - the counter width constant $clog2(WIDTH+1).
- One natural sub-module, div_step: combinational single iteration. Inputs are partial remainder, next dividend bit and |divisor|; outputs are new partial remainder and quotient bit.
- Top level holds the FSM, counter, sign handling and output registers.

Test Plan:
1. dividend=4900, divisor=-70 -> quotient=-70, remainder=0, flags 0; done after 10 edges, busy high for 9 cycles before.
2. dividend=-2765, divisor=40 -> quotient=-69, remainder=-5. Then dividend=2765, divisor=-40 -> quotient=-69, remainder=5.
3. dividend=9, divisor=0 -> div_by_zero=1, quotient=0, remainder=9, done after 2 edges. Next op dividend=1, divisor=1 -> flags cleared, quotient=1, remainder=0.
4. Overflow cases:
   - dividend=16384, divisor=1 -> early overflow, done after 2 edges.
   - dividend=128, divisor=1 -> late overflow, done after 10 edges.
   - dividend=-128, divisor=1 -> quotient=-128, no overflow.
5. Reset and ignored start: start with 100/7, pulse start with 50/5 at cycle 4 -> ignored; result quotient=14, remainder=2. New op, rst asserted in RUN cycle 3 -> next cycle busy=0, all outputs 0, no done.
6. Back-to-back: start held in the DONE cycle with dividend=-1, divisor=1 -> accepted immediately, quotient=-1, remainder=0 after 10 more edges; no idle cycle between done pulses beyond the DONE cycle.
